ps2_receiver: RTL
=================

PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter FILTER_LEN, default 4: number of consecutive identical samples needed before the filtered PS2_CLK/PS2_DATA level changes.
REQ-002 Parameter TIMEOUT_CYC, default 100000: maximum clk cycles allowed between PS2_CLK falling edges inside a frame (1 ms at 100 MHz).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 PS2_CLK  inout  1  PS/2 clock from the keyboard; this block only reads it and always drives high-Z.
REQ-006 PS2_DATA  inout  1  PS/2 data from the keyboard; this block only reads it and always drives high-Z.
REQ-007 key_in  output  8  last received data byte, excluding 0xE0 and 0xF0; held until the next data byte.
REQ-008 is_extend  output  1  one-cycle pulse when a good 0xE0 byte is received.
REQ-009 is_break  output  1  one-cycle pulse when a good 0xF0 byte is received.
REQ-010 valid  output  1  one-cycle pulse when key_in has just been updated.
REQ-011 err  output  1  one-cycle pulse when a frame is discarded.

Function
REQ-012 PS2_CLK and PS2_DATA SHALL each pass through a 2-FF synchronizer, then a FILTER_LEN-sample stability filter. Filtered level changes only after FILTER_LEN consecutive equal synchronized samples. Both lines use an identical pipeline depth.
REQ-013 A falling edge SHALL be the cycle in which filtered clock goes 1->0; filtered data is sampled in that same cycle.
REQ-014 FSM states SHALL be IDLE, RECV and DONE; reset state is IDLE.
REQ-015 IDLE: on a falling edge with data=0 (start bit), go to RECV with bit count 0 and timeout counter 0; a falling edge with data=1 stays in IDLE, with no err.
REQ-016 RECV: each falling edge shifts in the next bit. Order is 8 data bits LSB first, then the parity bit, then the stop bit. After the stop-bit edge (10th edge after start), go to DONE.
REQ-017 RECV: the timeout counter clears on every falling edge and increments otherwise. When it reaches TIMEOUT_CYC, discard the frame, pulse err and go to IDLE.
REQ-018 DONE (exactly one cycle) checks that the parity is odd, i.e. XOR of 8 data bits and parity bit = 1, and that stop=1. Always return to IDLE next cycle.
REQ-019 DONE, check fails: pulse err; key_in unchanged; no valid, is_extend or is_break.
REQ-020 DONE, check passes with byte 0xE0: pulse is_extend; key_in unchanged; no valid.
REQ-021 DONE, check passes with byte 0xF0: pulse is_break; key_in unchanged; no valid.
REQ-022 DONE, check passes with any other byte (including 0xAA): key_in <= byte and valid pulses in the same cycle.
REQ-023 Latency: output pulses SHALL assert in the cycle after the stop-bit falling edge is detected. At most one of valid, is_extend, is_break, err is high in any cycle.
REQ-024 Filtered glitches shorter than FILTER_LEN cycles SHALL produce no edge and no state change.
REQ-025 A falling edge arriving during DONE SHALL be ignored; the keyboard's minimum bit period exceeds the pipeline, so no frame is lost.
REQ-026 PS2_CLK and PS2_DATA SHALL never be driven (constant high-Z); no host-to-device transmission.

Reset
REQ-027 While rst is high, and asynchronously on its assertion, the block SHALL:
- clear key_in=0x00, valid=0, is_extend=0, is_break=0, err=0;
- set FSM to IDLE and clear the shift register, bit count and timeout counter;
- preset synchronizer and filter stages to 1 (idle bus level).
REQ-028 Reset mid-frame SHALL discard the partial frame with no err pulse. The first frame after reset release is received normally.

Verification
REQ-029 Frame 0x1D, parity 1, stop 1 -> key_in=0x1D and valid high exactly one cycle after the stop edge; is_extend/is_break/err stay 0.
REQ-030 Frame 0xE0 (parity 0), then frame 0x75 (parity 0) -> is_extend pulses once with key_in unchanged, then key_in=0x75 with a valid pulse.
REQ-031 Frame 0x1C sent with parity 1 (wrong) -> err pulses once; key_in keeps its previous value; no valid.
REQ-032 Start bit plus 4 data bits, then clock idle for TIMEOUT_CYC+10 cycles -> err pulses once. The following frame 0xAA (parity 1) gives key_in=0xAA and valid.
REQ-033 A 2-cycle low glitch on PS2_CLK in IDLE and during RECV -> no state change. The frame in progress still decodes correctly.
REQ-034 rst asserted after the 6th bit edge, then frame 0xF0 (parity 1) -> all outputs 0 during reset; afterwards is_break pulses once and there is no err.

Source files
------------

// File: rtl/ps2_receiver.sv
// -----------------------------------------------------------------------------
// ps2_receiver
// Receive-only PS/2 keyboard interface. Both bus lines are resynchronised,
// debounced by a stability filter and then decoded by a small frame FSM
// (start, 8 data bits LSB first, odd parity, stop). Prefix bytes 0xE0/0xF0
// are reported as pulses instead of being written to key_in.
//
// Parameters
//   FILTER_LEN  : consecutive equal samples needed to change a filtered level
//   TIMEOUT_CYC : max clk cycles between PS2_CLK falling edges inside a frame
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous, active-high reset
//   PS2_CLK   : PS/2 clock line (read only, never driven)
//   PS2_DATA  : PS/2 data line (read only, never driven)
//   key_in    : last good data byte other than 0xE0/0xF0
//   is_extend : 1-cycle pulse on a good 0xE0 byte
//   is_break  : 1-cycle pulse on a good 0xF0 byte
//   valid     : 1-cycle pulse when key_in takes a new byte
//   err       : 1-cycle pulse when a frame is discarded (parity/stop/timeout)
// -----------------------------------------------------------------------------
module ps2_receiver #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DATA,
  output logic [7:0] key_in,
  output logic       is_extend,
  output logic       is_break,
  output logic       valid,
  output logic       err
);

  localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  // Host-to-device transmission is not supported: the lines are only read.
  assign PS2_CLK  = 1'bz;
  assign PS2_DATA = 1'bz;

  // Index 0 = clock line, index 1 = data line; both get an identical
  // pipeline so the filtered data is aligned with the filtered clock.
  logic [1:0] line_in;
  logic [1:0] line_filt;

  assign line_in = {PS2_DATA, PS2_CLK};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [1:0]       sync_reg;
      logic             filt_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg <= 2'b11;
          filt_reg <= 1'b1;
          cnt_reg  <= '0;
        end else begin
          sync_reg <= {sync_reg[0], line_in[gi]};
          // cnt_reg counts consecutive samples that disagree with the
          // filtered level; any agreeing sample restarts the run.
          if (sync_reg[1] == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
            filt_reg <= sync_reg[1];
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign line_filt[gi] = filt_reg;
    end
  endgenerate

  logic ps2_clk_filt;
  logic ps2_data_filt;
  logic ps2_clk_d_reg;
  logic fall;

  assign ps2_clk_filt  = line_filt[0];
  assign ps2_data_filt = line_filt[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ps2_clk_d_reg <= 1'b1;
    else     ps2_clk_d_reg <= ps2_clk_filt;
  end

  assign fall = ps2_clk_d_reg & ~ps2_clk_filt;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [9:0]      shift_reg, shift_next;     // {stop, parity, data[7:0]} once full
  logic [3:0]      bit_cnt_reg, bit_cnt_next;
  logic [TO_W-1:0] timeout_reg, timeout_next;
  logic [7:0]      key_reg;
  logic            frame_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      timeout_reg <= '0;
      key_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      timeout_reg <= timeout_next;
      if (valid) key_reg <= shift_reg[7:0];
    end
  end

  // Odd parity over data+parity, and a high stop bit.
  assign frame_ok = (^shift_reg[8:0]) & shift_reg[9];

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    timeout_next = timeout_reg;
    valid        = 1'b0;
    is_extend    = 1'b0;
    is_break     = 1'b0;
    err          = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // A falling edge with data high is not a start bit; ignore it.
        if (fall && !ps2_data_filt) begin
          state_next   = RECV;
          bit_cnt_next = '0;
          timeout_next = '0;
          shift_next   = '0;
        end
      end

      RECV: begin
        if (fall) begin
          shift_next   = {ps2_data_filt, shift_reg[9:1]};
          timeout_next = '0;
          if (bit_cnt_reg == 4'd9) state_next   = DONE;
          else                     bit_cnt_next = bit_cnt_reg + 4'd1;
        end else if (timeout_reg == TO_W'(TIMEOUT_CYC)) begin
          err        = 1'b1;
          state_next = IDLE;
        end else begin
          timeout_next = timeout_reg + 1'b1;
        end
      end

      DONE: begin
        // Single evaluation cycle; any falling edge here is ignored since a
        // real keyboard bit period is far longer than this pipeline.
        state_next = IDLE;
        if (!frame_ok)                  err       = 1'b1;
        else if (shift_reg[7:0] == 8'hE0) is_extend = 1'b1;
        else if (shift_reg[7:0] == 8'hF0) is_break  = 1'b1;
        else                            valid     = 1'b1;
      end

      default: state_next = IDLE;
    endcase
  end

  // Bypass so key_in shows the new byte in the same cycle valid pulses.
  assign key_in = valid ? shift_reg[7:0] : key_reg;

endmodule
